led_scan_ctrl: RTL and testbench
================================

Name: led_scan_ctrl

Overview:
- Sequencer for the 3-to-8 one-hot LED decode stage: generates the 3-bit index, steps it on a prescaled timebase or a manual step pulse, and drives the decoded LED bus.
- Supports hold, count-up, count-down and ping-pong scan modes, plus a wrap/turn-around indication.
- Sits between the board switches/buttons and the LED outputs of the lab top level.

Parameters:
- DIV, 50_000_000, clock cycles per automatic step (legal range 1 .. 2^32-1).
- CW, 32, prescaler counter width (must satisfy 2^CW >= DIV).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  enables the prescaler (automatic stepping).
- mode  input  2  00 hold, 01 up, 10 down, 11 ping-pong.
- step  input  1  manual step level, already synchronous to clk; rising edge = one step request.
- idx  output  3  current scan index (registered).
- led  output  8  one-hot decode of idx: idx 0 -> 8'b1000_0000 … idx 7 -> 8'b0000_0001.
- tick  output  1  one-cycle pulse when the prescaler expires.
- wrap  output  1  one-cycle pulse on wrap or ping-pong turn-around.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: idx=0, led=8'h80, tick=0, wrap=0, prescaler count=0, dir=up, step_q=0.
- led is a pure combinational decode of the idx register; led and idx always change on the same edge. led is never all-zero and never multi-hot.
- Prescaler:
  - en=1: count increments each cycle. When count==DIV-1, count->0 and tick=1 for exactly that next cycle.
  - en=0: count held at 0, tick=0. Deasserting en mid-count discards the partial count.
  - DIV=1: tick is high every cycle while en=1.
- Step edge detect: step_q <= step; step_rise = step & ~step_q. A held-high step produces one request only.
- Advance event: adv = tick_pending | step_rise, where tick_pending is the prescaler-expiry condition. A tick and a step_rise in the same cycle give ONE advance, not two.
- On adv, idx updates on the next edge according to mode:
  - 00 hold: idx unchanged, wrap=0. The prescaler keeps running.
  - 01 up: idx+1 mod 8. 7->0 asserts wrap.
  - 10 down: idx-1 mod 8. 0->7 asserts wrap.
  - 11 ping-pong, dir=up: idx<7 -> idx+1; idx==7 -> idx=6, dir=down, wrap=1.
  - 11 ping-pong, dir=down: idx>0 -> idx-1; idx==0 -> idx=1, dir=up, wrap=1.
  - Ping-pong sequence from reset: 0,1,…,7,6,…,0,1,… with no repeated endpoint.
- dir is only updated in mode 11 and retains its value across mode changes.
- Changing mode never alters idx by itself; the new mode applies from the next adv.
- wrap is registered and coincident with the idx update that causes it; one cycle wide.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to reset values. The first tick after release arrives DIV cycles after the first cycle with en=1.

Test Plan (DIV=4 unless noted):
- Reset/idle: assert rst, en=0, mode=01 -> idx=0, led=8'h80, tick=0, wrap=0. Release rst, wait 20 cycles -> no change.
- Up scan: en=1, mode=01 -> tick every 4th cycle; idx 0,1,…,7,0; led 80,40,20,10,08,04,02,01,80; wrap=1 exactly on the 7->0 update.
- Down and hold: en=0, mode=10, three step rising edges -> idx 0->7->6->5, wrap only on 0->7. Then mode=00, pulse step -> idx stays 5. Hold step high 10 cycles -> only one request counted.
- Ping-pong: from idx 0, mode=11, 16 step edges -> idx 1..7,6..0,1,2; wrap pulses at 7->6 and 0->1. Switch to mode=01 then back to 11 -> dir preserved.
- Coincidence: en=1 and step rising in the same cycle the prescaler expires, mode=01, idx=3 -> idx=4, not 5.
- Async reset mid-run: at idx=5, mode=11, dir=down, assert rst between clock edges -> idx=0, led=8'h80 before the next edge. After release, the first tick comes 4 cycles after en, and dir=up.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// Purpose: scan-index sequencer for the 3-to-8 one-hot LED stage (hold/up/down/ping-pong).
// Latency: idx/led/wrap update on the edge after an advance request; tick one cycle after expiry.
// Backpressure: none; steps are fire-and-forget, and a tick plus step in one cycle merge into one advance.
//
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - asynchronous active-high reset
//   en   - enables the prescaler; low clears the partial count
//   mode - 00 hold, 01 up, 10 down, 11 ping-pong
//   step - manual step level (synchronous); each rising edge requests one step
//   idx  - registered scan index
//   led  - one-hot decode of idx, idx 0 lights bit 7
//   tick - one-cycle pulse when the prescaler expires
//   wrap - one-cycle pulse on wrap-around or ping-pong turn-around
module led_scan_ctrl #(
    parameter int unsigned DIV = 50_000_000,
    parameter int          CW  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       step,
    output logic [2:0] idx,
    output logic [7:0] led,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_PING = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          step_q;
    dir_t          dir;
    dir_t          dir_nxt;
    logic [2:0]    idx_nxt;
    logic          wrap_nxt;
    logic          tick_pending;
    logic          step_rise;
    logic          adv;

    // Expiry is decoded from the current count so the index can move on the
    // same edge that raises tick.
    assign tick_pending = en && (cnt == CNT_LAST);
    assign step_rise    = step & ~step_q;
    // OR, not sum: a coincident tick and step request produce a single advance.
    assign adv          = tick_pending | step_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            tick   <= 1'b0;
            step_q <= 1'b0;
            idx    <= 3'd0;
            dir    <= DIR_UP;
            wrap   <= 1'b0;
        end else begin
            if (!en || tick_pending) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            tick   <= tick_pending;
            step_q <= step;
            idx    <= idx_nxt;
            dir    <= dir_nxt;
            wrap   <= wrap_nxt;
        end
    end

    always_comb begin
        idx_nxt  = idx;
        dir_nxt  = dir;
        wrap_nxt = 1'b0;
        if (adv) begin
            case (mode)
                MODE_UP: begin
                    idx_nxt  = idx + 3'd1;
                    wrap_nxt = (idx == 3'd7);
                end
                MODE_DOWN: begin
                    idx_nxt  = idx - 3'd1;
                    wrap_nxt = (idx == 3'd0);
                end
                MODE_PING: begin
                    // Endpoints bounce straight to their neighbour so the
                    // endpoint value is never shown twice in a row.
                    if (dir == DIR_UP) begin
                        if (idx == 3'd7) begin
                            idx_nxt  = 3'd6;
                            dir_nxt  = DIR_DOWN;
                            wrap_nxt = 1'b1;
                        end else begin
                            idx_nxt = idx + 3'd1;
                        end
                    end else begin
                        if (idx == 3'd0) begin
                            idx_nxt  = 3'd1;
                            dir_nxt  = DIR_UP;
                            wrap_nxt = 1'b1;
                        end else begin
                            idx_nxt = idx - 3'd1;
                        end
                    end
                end
                MODE_HOLD: begin
                    idx_nxt = idx;
                end
                default: begin
                    idx_nxt = idx;
                end
            endcase
        end
    end

    // Shifting a single set bit can never yield zero or multiple hot bits.
    always_comb begin
        led = 8'h80 >> idx;
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Purpose: directed self-checking bench for led_scan_ctrl with DIV=4.
// Latency: expectations are queued when a step/tick is provoked and popped one edge later.
// Backpressure: none; a watchdog bounds the whole run.
module tb_led_scan_ctrl;

    localparam int DIV = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic       step = 1'b0;
    logic [1:0] mode = 2'b01;
    logic [2:0] idx;
    logic [7:0] led;
    logic       tick;
    logic       wrap;

    led_scan_ctrl #(
        .DIV (DIV),
        .CW  (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .step (step),
        .idx  (idx),
        .led  (led),
        .tick (tick),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    typedef struct {
        string      tag;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    exp_t sb[$];

    logic [7:0] led_tab [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [2:0] pp_tab [22] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                                3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2,
                                3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [2:0] e_idx, input logic e_wrap);
        exp_t e;
        e.tag  = tag;
        e.idx  = e_idx;
        e.wrap = e_wrap;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            failed++;
            $error("FAIL sb_underflow: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_idx"},  idx,  e.idx);
        chk({e.tag, "_led"},  led,  led_tab[e.idx]);
        chk({e.tag, "_wrap"}, wrap, e.wrap);
    endtask

    // One clean step edge: check the update, then that wrap drops and idx holds.
    task automatic pulse_step(input string tag, input logic [2:0] e_idx, input logic e_wrap);
        push_exp(tag, e_idx, e_wrap);
        step = 1'b1;
        cyc();
        pop_check();
        step = 1'b0;
        cyc();
        chk({tag, "_wrap_off"}, wrap, 1'b0);
        chk({tag, "_hold"},     idx,  e_idx);
    endtask

    // Edges until tick is seen, bounded so a dead prescaler cannot hang the run.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < 3 * DIV);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset and idle
        repeat (2) cyc();
        chk("rst_idx",  idx,  3'd0);
        chk("rst_led",  led,  8'h80);
        chk("rst_tick", tick, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_idx",  idx,  3'd0);
            chk("idle_tick", tick, 1'b0);
        end

        // Automatic up scan
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            push_exp($sformatf("up%0d", k), 3'(k % 8), k == 8);
            wait_tick(n);
            chk($sformatf("up%0d_gap", k), n, DIV);
            pop_check();
        end
        en = 1'b0;
        cyc();

        // Manual down steps
        mode = 2'b10;
        pulse_step("dn7", 3'd7, 1'b1);
        pulse_step("dn6", 3'd6, 1'b0);
        pulse_step("dn5", 3'd5, 1'b0);

        // Hold mode ignores steps
        mode = 2'b00;
        pulse_step("hold", 3'd5, 1'b0);

        // Step held high gives one request only
        mode = 2'b01;
        push_exp("held", 3'd6, 1'b0);
        step = 1'b1;
        cyc();
        pop_check();
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("held_once", idx, 3'd6);
        end
        step = 1'b0;
        cyc();
        chk("held_release", idx, 3'd6);
        pulse_step("up7b", 3'd7, 1'b0);
        pulse_step("up0b", 3'd0, 1'b1);

        // Ping-pong from idx 0
        mode = 2'b11;
        cyc();
        chk("pp_mode_noop", idx, 3'd0);
        for (int i = 0; i < 22; i++) begin
            pulse_step($sformatf("pp%0d", i), pp_tab[i], (i == 7) || (i == 14) || (i == 21));
        end

        // dir (now down) survives excursions into other modes
        mode = 2'b01;
        cyc();
        chk("pp_to_up_noop", idx, 3'd6);
        pulse_step("pp_up", 3'd7, 1'b0);
        mode = 2'b10;
        pulse_step("pp_dn", 3'd6, 1'b0);
        mode = 2'b11;
        pulse_step("pp_dir_kept", 3'd5, 1'b0);

        // Tick and step in the expiry cycle merge into one advance
        mode = 2'b10;
        pulse_step("pre_c4", 3'd4, 1'b0);
        pulse_step("pre_c3", 3'd3, 1'b0);
        mode = 2'b01;
        en   = 1'b1;
        repeat (DIV - 1) cyc();
        step = 1'b1;
        push_exp("coinc", 3'd4, 1'b0);
        cyc();
        chk("coinc_tick", tick, 1'b1);
        pop_check();
        step = 1'b0;
        en   = 1'b0;
        cyc();
        chk("coinc_after1", idx, 3'd4);
        cyc();
        chk("coinc_after2", idx, 3'd4);

        // Asynchronous reset mid-run in ping-pong, dir down
        pulse_step("pre_r5", 3'd5, 1'b0);
        mode = 2'b11;
        en   = 1'b1;
        cyc();
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_idx",  idx,  3'd0);
        chk("arst_led",  led,  8'h80);
        chk("arst_tick", tick, 1'b0);
        chk("arst_wrap", wrap, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp("post_rst1", 3'd1, 1'b0);
        wait_tick(n);
        chk("post_rst_gap1", n, DIV);
        pop_check();
        push_exp("post_rst2", 3'd2, 1'b0);
        wait_tick(n);
        chk("post_rst_gap2", n, DIV);
        pop_check();
        en = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
